// File: rtl/uart_pkg.sv
// Shared UART constants and RX/TX state encoding for both serial channels.
package uart_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 115_200;
  localparam int BIT_TICKS  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Cycles per bit, rounded to nearest, for non-default clock/baud choices.
  function automatic int calc_ticks(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-level valid/ready link between a uart_channel and its user logic.
interface uart_if;

  logic [7:0] tx_dat;
  logic       tx_vld;
  logic       tx_rdy;
  logic [7:0] rx_dat;
  logic       rx_vld;

  modport master (output tx_dat, tx_vld, input tx_rdy, rx_dat, rx_vld);
  modport slave  (input tx_dat, tx_vld, output tx_rdy, rx_dat, rx_vld);

endinterface

// File: rtl/uart_channel.sv
// One 8N1 channel: 2-flop rxd sync, mid-bit sampling RX, registered-line TX.
// rx_vld is a 1-cycle pulse with no backpressure; tx_rdy is high only while TX is idle.
module uart_channel import uart_pkg::*; #(
  parameter int TICKS = BIT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  uart_if.slave bus
);

  localparam int CW = $clog2(TICKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICKS / 2 - 1);

  logic rx_meta, rx_sync, rx_prev;

  uart_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic rx_vld_q, rx_vld_n;

  uart_state_t tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic txd_n;

  assign bus.rx_dat = rx_shift;
  assign bus.rx_vld = rx_vld_q;
  assign bus.tx_rdy = (tx_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_vld_q <= 1'b0;
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_vld_q <= rx_vld_n;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_vld_n   = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = START;
      end
      START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? IDLE : DATA;
      end
      DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_state_n = STOP;
      end
      STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_vld_n   = rx_sync;
        rx_state_n = IDLE;
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // The line register follows the next state so each bit holds exactly TICKS cycles.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (bus.tx_vld) begin
          tx_shift_n = bus.tx_dat;
          tx_state_n = START;
        end
      end
      START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = DATA;
      end
      DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_bit_n   = tx_bit + 1'b1;
        if (tx_bit == 3'd7) tx_state_n = STOP;
      end
      STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
    txd_n = 1'b1;
    if (tx_state_n == START)     txd_n = 1'b0;
    else if (tx_state_n == DATA) txd_n = tx_shift_n[0];
  end

endmodule

// File: rtl/uart_top.sv
// Primary echo + aux forward onto rs232_txd (echo wins ties), button-triggered aux send.
// Pending bytes wait one per source; a byte arriving at a full pending register is dropped.
module uart_top #(
  parameter int CLK_HZ = uart_pkg::CLK_HZ,
  parameter int BAUD   = uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic [3:0] buttons,
  input  logic [7:0] switches,
  input  logic       rs232_rxd,
  output logic       rs232_txd,
  input  logic       rs232_rxd_a,
  output logic       rs232_txd_a
);

  import uart_pkg::*;

  localparam int TICKS = calc_ticks(CLK_HZ, BAUD);

  logic rst;
  logic unused_buttons;
  logic btn_meta, btn_sync, btn_prev, press;
  logic aux_pend;
  logic [7:0] aux_dat;
  logic echo_pend, fwd_pend;
  logic [7:0] echo_dat, fwd_dat;
  logic take_echo, take_fwd;

  assign rst            = buttons[3];
  assign unused_buttons = &{1'b0, buttons[2:1]};

  uart_if prim ();
  uart_if aux ();

  uart_channel #(.TICKS(TICKS)) u_prim (
    .clk(clk), .rst(rst), .rxd(rs232_rxd), .txd(rs232_txd), .bus(prim.slave)
  );

  uart_channel #(.TICKS(TICKS)) u_aux (
    .clk(clk), .rst(rst), .rxd(rs232_rxd_a), .txd(rs232_txd_a), .bus(aux.slave)
  );

  assign press       = btn_sync & ~btn_prev;
  assign aux.tx_vld  = aux_pend;
  assign aux.tx_dat  = aux_dat;

  assign take_echo    = echo_pend & prim.tx_rdy;
  assign take_fwd     = fwd_pend & ~echo_pend & prim.tx_rdy;
  assign prim.tx_vld  = echo_pend | fwd_pend;
  assign prim.tx_dat  = echo_pend ? echo_dat : fwd_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      btn_prev  <= 1'b1;
      aux_pend  <= 1'b0;
      aux_dat   <= '0;
      echo_pend <= 1'b0;
      echo_dat  <= '0;
      fwd_pend  <= 1'b0;
      fwd_dat   <= '0;
    end else begin
      btn_meta <= buttons[0];
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;

      // A press only counts while the aux transmitter is idle.
      if (aux_pend) begin
        if (aux.tx_rdy) aux_pend <= 1'b0;
      end else if (press && aux.tx_rdy) begin
        aux_pend <= 1'b1;
        aux_dat  <= switches;
      end

      if (take_echo) echo_pend <= 1'b0;
      else if (prim.rx_vld && !echo_pend) begin
        echo_pend <= 1'b1;
        echo_dat  <= prim.rx_dat;
      end

      if (take_fwd) fwd_pend <= 1'b0;
      else if (aux.rx_vld && !fwd_pend) begin
        fwd_pend <= 1'b1;
        fwd_dat  <= aux.rx_dat;
      end
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: frame vector table plus hand-written multi-cycle sequences.
module tb_uart_top;

  localparam int BIT  = 434;
  localparam int HALF = 217;

  typedef struct {
    logic [7:0] din;
    bit         stop_good;
    bit         echo;
  } vec_t;

  logic       clk = 1'b0;
  logic [3:0] buttons;
  logic [7:0] switches;
  logic       rxd_drv, rxd_a_drv, loop_en;
  logic       rs232_rxd, rs232_txd, rs232_rxd_a, rs232_txd_a;
  longint     cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  bit         f_found, g_found, h_found, f_shape, g_shape, h_shape;
  logic [7:0] f_dat, g_dat, h_dat;
  longint     f_t0, g_t0, h_t0, t_send;
  vec_t       vecs [3];

  uart_if mon ();

  assign rs232_rxd   = rxd_drv;
  assign rs232_rxd_a = loop_en ? rs232_txd_a : rxd_a_drv;

  uart_top dut (
    .clk(clk), .buttons(buttons), .switches(switches),
    .rs232_rxd(rs232_rxd), .rs232_txd(rs232_txd),
    .rs232_rxd_a(rs232_rxd_a), .rs232_txd_a(rs232_txd_a)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input bit aux, input logic [7:0] d, input bit stop_good);
    logic [9:0] bits;
    bits = {stop_good, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      if (aux) rxd_a_drv = bits[b]; else rxd_drv = bits[b];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk);
    if (aux) rxd_a_drv = 1'b1; else rxd_drv = 1'b1;
  endtask

  // Waits for a start bit, then checks every cycle of every bit window is constant.
  task automatic get_frame(input bit aux, input int timeout, output bit found,
                           output logic [7:0] dat, output bit shape, output longint t0);
    logic lvl, first;
    found = 1'b0; shape = 1'b1; dat = '0; t0 = 0; first = 1'b1;
    for (int i = 0; i < timeout && !found; i++) begin
      @(negedge clk);
      lvl = aux ? rs232_txd_a : rs232_txd;
      if (!lvl) found = 1'b1;
    end
    if (found) begin
      t0 = cyc;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < BIT; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          lvl = aux ? rs232_txd_a : rs232_txd;
          if (c == 0) first = lvl;
          else if (lvl !== first) shape = 1'b0;
          if ((b == 0 && lvl !== 1'b0) || (b == 9 && lvl !== 1'b1)) shape = 1'b0;
          if (b >= 1 && b <= 8 && c == HALF) dat[b-1] = lvl;
        end
      end
    end
  endtask

  initial begin
    #(20 * 90_000);
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit ok_p, ok_a, seen;
    buttons = 4'b1000; switches = 8'h00;
    rxd_drv = 1'b1; rxd_a_drv = 1'b1; loop_en = 1'b0;
    mon.tx_dat = '0; mon.tx_vld = 1'b0; mon.tx_rdy = 1'b0;
    mon.rx_dat = '0; mon.rx_vld = 1'b0;

    vecs[0] = '{din: 8'h55, stop_good: 1'b1, echo: 1'b1};
    vecs[1] = '{din: 8'h3C, stop_good: 1'b0, echo: 1'b0};
    vecs[2] = '{din: 8'h3C, stop_good: 1'b1, echo: 1'b1};

    repeat (3) @(negedge clk);
    check("reset_txd", rs232_txd, 1);
    check("reset_txd_a", rs232_txd_a, 1);
    buttons[3] = 1'b0;
    repeat (5) @(negedge clk);
    buttons[3] = 1'b1;
    @(negedge clk);
    buttons[3] = 1'b0;
    ok_p = 1'b1; ok_a = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rs232_txd !== 1'b1) ok_p = 1'b0;
      if (rs232_txd_a !== 1'b1) ok_a = 1'b0;
    end
    check("idle_txd", ok_p, 1);
    check("idle_txd_a", ok_a, 1);

    for (int i = 0; i < 3; i++) begin
      t_send = cyc;
      fork
        send_frame(1'b0, vecs[i].din, vecs[i].stop_good);
        get_frame(1'b0, 12 * BIT, f_found, f_dat, f_shape, f_t0);
      join
      mon.rx_dat = f_dat;
      mon.rx_vld = f_found;
      check($sformatf("vec%0d_found", i), mon.rx_vld, vecs[i].echo);
      if (vecs[i].echo && f_found) begin
        check($sformatf("vec%0d_dat", i), mon.rx_dat, vecs[i].din);
        check($sformatf("vec%0d_width", i), f_shape, 1);
        if (i == 0)
          check("echo_latency",
                (f_t0 - t_send >= 9 * BIT + HALF) && (f_t0 - t_send <= 10 * BIT + HALF), 1);
      end
    end

    loop_en = 1'b1;
    switches = 8'hA5;
    fork
      begin
        @(negedge clk); buttons[0] = 1'b1;
        repeat (3) @(negedge clk); buttons[0] = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        switches = 8'h0F; buttons[0] = 1'b1;
        repeat (3) @(negedge clk); buttons[0] = 1'b0;
      end
      begin
        get_frame(1'b1, 200, g_found, g_dat, g_shape, g_t0);
        get_frame(1'b1, 2 * BIT, h_found, h_dat, h_shape, h_t0);
      end
      get_frame(1'b0, 12 * BIT, f_found, f_dat, f_shape, f_t0);
    join
    check("aux_found", g_found, 1);
    check("aux_dat", g_dat, 8'hA5);
    check("aux_width", g_shape, 1);
    check("aux_busy_press_ignored", h_found, 0);
    check("fwd_dat", f_dat, 8'hA5);
    check("fwd_after_aux", f_found && (f_t0 > g_t0), 1);
    loop_en = 1'b0;
    switches = 8'h00;

    seen = 1'b0;
    fork
      send_frame(1'b0, 8'h55, 1'b1);
      begin
        for (int i = 0; i < 12 * BIT && !seen; i++) begin
          @(negedge clk);
          if (!rs232_txd) seen = 1'b1;
        end
        check("rst_echo_started", seen, 1);
        repeat (4 * BIT + HALF) @(negedge clk);
        check("rst_pre_low", rs232_txd, 0);
        buttons[3] = 1'b1;
        #1;
        check("rst_abort_txd", rs232_txd, 1);
      end
    join
    repeat (4) @(negedge clk);
    buttons[3] = 1'b0;
    get_frame(1'b0, 3 * BIT, f_found, f_dat, f_shape, f_t0);
    check("rst_no_residual", f_found, 0);
    check("rst_txd_a_idle", rs232_txd_a, 1);

    fork
      send_frame(1'b0, 8'h11, 1'b1);
      send_frame(1'b1, 8'h22, 1'b1);
      begin
        get_frame(1'b0, 12 * BIT, f_found, f_dat, f_shape, f_t0);
        get_frame(1'b0, 8, g_found, g_dat, g_shape, g_t0);
      end
    join
    check("arb_first", f_found ? {24'h0, f_dat} : 32'hFFFF_FFFF, 8'h11);
    check("arb_second", g_found ? {24'h0, g_dat} : 32'hFFFF_FFFF, 8'h22);
    check("arb_back_to_back",
          g_found && (g_t0 - f_t0 >= 10 * BIT) && (g_t0 - f_t0 <= 10 * BIT + 4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameters SHALL be: CLK_HZ, default 50_000_000, input clock frequency; BAUD, default 115200, line rate for both channels.
REQ-002 clk  input  1  system clock (single clock domain, 50 MHz nominal).
REQ-003 buttons  input  4  buttons[3] is the reset, asynchronous and active-high; buttons[0] is the aux-send request; buttons[2:1] are unused.
REQ-004 switches  input  8  data byte sent on the aux channel.
REQ-005 rs232_rxd  input  1  primary serial receive line, idle high.
REQ-006 rs232_txd  output  1  primary serial transmit line, idle high.
REQ-007 rs232_rxd_a  input  1  aux serial receive line, idle high.
REQ-008 rs232_txd_a  output  1  aux serial transmit line, idle high.

Function
REQ-009 Both channels SHALL use 8N1 framing, LSB first, with BIT_TICKS = CLK_HZ/BAUD rounded to nearest (434 at defaults).
REQ-010 Every serial input and buttons[0] SHALL pass through a 2-flop synchronizer before use.
REQ-011 RX states SHALL be IDLE, START, DATA, STOP.
- IDLE->START on a synchronized falling edge.
- START->DATA if the line is still low at BIT_TICKS/2; START->IDLE if it is high (glitch).
- DATA samples each bit at mid-bit; after 8 bits go to STOP.
- STOP samples at mid-bit: high means byte valid for exactly 1 cycle; low means framing error, byte discarded. Either way return to IDLE.
REQ-012 TX states SHALL be IDLE, START, DATA, STOP; each bit SHALL last exactly BIT_TICKS cycles.
- TX accepts a byte only in IDLE.
- The start bit begins on the cycle after acceptance.
- TX returns to IDLE after one full stop bit.
REQ-013 Primary echo: each valid byte from rs232_rxd SHALL be transmitted on rs232_txd.
REQ-014 Aux send: a synchronized rising edge on buttons[0] SHALL latch switches and transmit the byte on rs232_txd_a.
- A press while aux TX is busy is ignored.
REQ-015 Aux forward: each valid byte from rs232_rxd_a SHALL also be transmitted on rs232_txd.
REQ-016 Primary TX arbitration: one pending register per source (echo, forward).
- Echo has priority when both are pending in the same cycle.
- A new byte arriving while its source's pending register is full SHALL be dropped; the pending byte is kept.
REQ-017 No output SHALL depend combinationally on any input; all outputs are registered.

Reset
REQ-018 While buttons[3] is high, all state machines SHALL be IDLE, pending registers empty, counters zero, synchronizers set to 1, and rs232_txd and rs232_txd_a held high.
REQ-019 Assertion mid-frame SHALL abort any transfer immediately, with the line high; no partial byte is delivered after release.
REQ-020 After release, the first cycle SHALL be normal IDLE operation; no spurious start bit is generated.

Structure
REQ-021 Package uart_pkg SHALL hold CLK_HZ, BAUD, BIT_TICKS, HALF_TICKS and the RX/TX state enum.
REQ-022 One sub-module uart_channel (synchronizer + RX + TX, byte valid/ready ports) SHALL be instantiated twice: primary and aux.
REQ-023 Echo/forward arbitration and the buttons[0] edge detector SHALL live in uart_top.

Verification
REQ-024 One-cycle reset pulse, all other inputs idle (buttons[2:0]=0, switches=0, rxd lines 1) -> rs232_txd and rs232_txd_a stay 1 for the following 10+ cycles.
REQ-025 Send 0x55 on rs232_rxd at 115200 -> start bit on rs232_txd within 1 bit time after the RX stop-bit sample, frame carries 0x55, 434-cycle bit width (+/-0).
REQ-026 With rs232_txd_a looped to rs232_rxd_a, switches=0xA5, pulse buttons[0] -> 0xA5 frame on rs232_txd_a, then 0xA5 frame on rs232_txd.
REQ-027 Frame 0x3C with the stop bit driven low -> no output frame on rs232_txd; a following good 0x3C is echoed.
REQ-028 Assert buttons[3] in the middle of the 0x55 echo -> rs232_txd goes high immediately; after release, idle-high with no residual frame.
REQ-029 Simultaneous echo (0x11) and forward (0x22) pending -> rs232_txd sends 0x11 then 0x22 back-to-back.
